// File: rtl/register_file.sv
// 32-entry register file: two combinational mux32 read ports, one write port, sequential clear engine.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.

module mux32 #(
  parameter int W = 32
) (
  input  logic [31:0][W-1:0] din,
  input  logic [4:0]         sel,
  output logic [W-1:0]       dout
);
  assign dout = din[sel];
endmodule

module register_file #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  logic [4:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [4:0]   rd_addr0,
  output logic [N-1:0] rd_data0,
  input  logic [4:0]   rd_addr1,
  output logic [N-1:0] rd_data1,
  input  logic         clr_req,
  output logic         busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [4:0]          clr_idx;
  logic [N-1:0]        regs [1:31];
  logic [31:0][N-1:0]  mux_in;
  logic [N-1:0]        mux_out0;
  logic [N-1:0]        mux_out1;
  logic                wr_go;

  assign wr_go = wr_ena && !busy && (wr_addr != 5'd0);

  // NOTE: state uses non-blocking assignments only, so every register sees
  // pre-edge values regardless of statement order inside the block.
  // NOTE: the storage array is reset explicitly because reset must zero the
  // architectural contents, not just the control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      clr_idx <= '0;
      busy    <= 1'b0;
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (state == IDLE && wr_go && wr_addr == 5'(i)) regs[i] <= wr_data;
        if (state == CLEAR && clr_idx == 5'(i))         regs[i] <= '0;
      end

      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_idx <= 5'd1;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          // The 5-bit index wraps 31 -> 0 as the engine leaves CLEAR.
          clr_idx <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    mux_in[0] = '0;
    for (int i = 1; i < 32; i++) mux_in[i] = regs[i];
  end

  mux32 #(.W(N)) u_rd_mux0 (.din(mux_in), .sel(rd_addr0), .dout(mux_out0));
  mux32 #(.W(N)) u_rd_mux1 (.din(mux_in), .sel(rd_addr1), .dout(mux_out1));

`ifdef REGFILE_BYPASS_EN
  assign rd_data0 = (wr_go && rd_addr0 == wr_addr) ? wr_data : mux_out0;
  assign rd_data1 = (wr_go && rd_addr1 == wr_addr) ? wr_data : mux_out1;
`else
  assign rd_data0 = mux_out0;
  assign rd_data1 = mux_out1;
`endif

endmodule
